// File: rtl/dmem_responder.sv
// Data-memory responder for a simple core data port.
// Fixed-latency handshake: a request accepted in IDLE completes with a one-cycle
// ready_o pulse WAIT_STATES+1 cycles later. Writes commit at the end of the RESP cycle.
// Optional timer (mtime/mtimecmp plus irq_o) is compiled in when DMEM_TIMER_EN is defined.
// The timer window always shadows storage. With the timer absent, that window reads as 0
// and writes to it are dropped.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] TIMER_ADDR  = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:2]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    we_q, we_d;

  logic [31:0]   word_addr;
  logic [31:0]   off;
  logic [IDX_W-1:0] idx;
  logic          in_mem, tmr_lo, tmr_hi, mem_hit, is_read, resp;

  logic [31:0]   mem_q [DEPTH_WORDS];

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          addr_d  = addr_i[31:2];
          wdata_d = wdata_i;
          we_d    = we_i;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode of the latched request; the timer window shadows storage
  always_comb begin
    word_addr = {addr_q, 2'b00};
    off       = word_addr - BASE_ADDR;
    idx       = IDX_W'(off >> 2);
    in_mem    = (word_addr >= BASE_ADDR) && ({32'b0, off} < SPAN);
    tmr_lo    = (word_addr == TIMER_ADDR);
    tmr_hi    = (word_addr == TIMER_ADDR + 32'd4);
    mem_hit   = in_mem && !(tmr_lo || tmr_hi);
    is_read   = (we_q == '0);
    resp      = (state_q == S_RESP);
  end

  assign ready_o = resp;

  // Byte-enabled storage write at the edge ending RESP; storage itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && resp && mem_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (we_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        irq_q;
  logic        wr_en;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Timer next values: a bus write to mtime replaces that cycle's increment
  always_comb begin
    wr_en      = resp && !is_read;
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr_en && tmr_lo) mtime_d    = merge(mtime_q, wdata_q, we_q);
    if (wr_en && tmr_hi) mtimecmp_d = merge(mtimecmp_q, wdata_q, we_q);
  end

  // Timer registers and registered compare
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  // Read data is driven only during a read RESP
  always_comb begin
    rdata_o = '0;
    if (resp && is_read) begin
      if (tmr_lo)       rdata_o = mtime_q;
      else if (tmr_hi)  rdata_o = mtimecmp_q;
      else if (mem_hit) rdata_o = mem_q[idx];
    end
  end

  assign irq_o = irq_q;
`else
  // Read data is driven only during a read RESP
  always_comb begin
    rdata_o = '0;
    if (resp && is_read && mem_hit) rdata_o = mem_q[idx];
  end

  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_dmem_responder;

  localparam int N = 3;
  localparam int unsigned WS_P    [N] = '{1, 0, 3};
  localparam int unsigned DEPTH_P [N] = '{1024, 64, 16};
  localparam logic [31:0] BASE_P  [N] = '{32'h0000_0000, 32'h0000_1000, 32'h8000_0000};
  localparam logic [31:0] TADDR_P [N] = '{32'h0002_0000, 32'h0000_1080, 32'h0002_0000};
`ifdef DMEM_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s   [N];
  logic        valid_s [N];
  logic        ready_s [N];
  logic        irq_s   [N];
  logic [31:0] addr_s  [N];
  logic [31:0] wdata_s [N];
  logic [31:0] rdata_s [N];
  logic [3:0]  we_s    [N];

  dmem_responder #(.DEPTH_WORDS(DEPTH_P[0]), .BASE_ADDR(BASE_P[0]), .WAIT_STATES(WS_P[0]),
                   .TIMER_ADDR(TADDR_P[0])) u_dut_a (
    .clk(clk), .rst(rst_s[0]), .valid_i(valid_s[0]), .ready_o(ready_s[0]), .addr_i(addr_s[0]),
    .wdata_i(wdata_s[0]), .we_i(we_s[0]), .rdata_o(rdata_s[0]), .irq_o(irq_s[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH_P[1]), .BASE_ADDR(BASE_P[1]), .WAIT_STATES(WS_P[1]),
                   .TIMER_ADDR(TADDR_P[1])) u_dut_b (
    .clk(clk), .rst(rst_s[1]), .valid_i(valid_s[1]), .ready_o(ready_s[1]), .addr_i(addr_s[1]),
    .wdata_i(wdata_s[1]), .we_i(we_s[1]), .rdata_o(rdata_s[1]), .irq_o(irq_s[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH_P[2]), .BASE_ADDR(BASE_P[2]), .WAIT_STATES(WS_P[2]),
                   .TIMER_ADDR(TADDR_P[2])) u_dut_c (
    .clk(clk), .rst(rst_s[2]), .valid_i(valid_s[2]), .ready_o(ready_s[2]), .addr_i(addr_s[2]),
    .wdata_i(wdata_s[2]), .we_i(we_s[2]), .rdata_o(rdata_s[2]), .irq_o(irq_s[2]));

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] mem_m  [N][1024];
  logic [3:0]  kn_m   [N][1024];
  int          pend_c [N];
  int          free_c [N];
  logic [31:0] la_a   [N];
  logic [31:0] la_w   [N];
  logic [3:0]  la_we  [N];
  logic [31:0] mt_m   [N];
  logic [31:0] mc_m   [N];
  logic        irq_m  [N];
  bit          armed  [N];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // 0: nothing, 1: storage word idx, 2: mtime, 3: mtimecmp
  function automatic int decode(input int k, input logic [31:0] a, output int idx);
    logic [31:0] aw;
    aw  = {a[31:2], 2'b00};
    idx = 0;
    if (aw == TADDR_P[k]) return TIMER_ON ? 2 : 0;
    if (aw == TADDR_P[k] + 32'd4) return TIMER_ON ? 3 : 0;
    if (aw >= BASE_P[k] && (aw - BASE_P[k]) < 4 * DEPTH_P[k]) begin
      idx = int'((aw - BASE_P[k]) >> 2);
      return 1;
    end
    return 0;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      pend_c[k] = -1; free_c[k] = 0; armed[k] = 1'b0; irq_m[k] = 1'b0;
      mt_m[k] = '0; mc_m[k] = '1; la_a[k] = '0; la_w[k] = '0; la_we[k] = '0;
      for (int i = 0; i < 1024; i++) begin mem_m[k][i] = '0; kn_m[k][i] = '0; end
    end
  end

  // Compare process: expected outputs of this cycle, then advance the model
  always @(negedge clk) begin : model
    bit          er, known;
    logic [31:0] ed, nmt;
    int          rg, idx;
    for (int k = 0; k < N; k++) begin
      er = armed[k] && (pend_c[k] == cyc);
      ed = '0;
      known = 1'b1;
      if (er && la_we[k] == 4'h0) begin
        rg = decode(k, la_a[k], idx);
        case (rg)
          1: if (kn_m[k][idx] == 4'hF) ed = mem_m[k][idx]; else known = 1'b0;
          2: ed = mt_m[k];
          3: ed = mc_m[k];
          default: ed = '0;
        endcase
      end
      if (armed[k]) begin
        check($sformatf("model_ready[%0d]", k), {31'b0, ready_s[k]}, {31'b0, er});
        if (known) check($sformatf("model_rdata[%0d]", k), rdata_s[k], ed);
        check($sformatf("model_irq[%0d]", k), {31'b0, irq_s[k]}, {31'b0, irq_m[k]});
      end
      if (rst_s[k]) begin
        pend_c[k] = -1; free_c[k] = cyc + 1;
        mt_m[k] = '0; mc_m[k] = '1; irq_m[k] = 1'b0; armed[k] = 1'b1;
      end else if (armed[k]) begin
        irq_m[k] = TIMER_ON && (mt_m[k] >= mc_m[k]);
        nmt = mt_m[k] + 32'd1;
        if (er && la_we[k] != 4'h0) begin
          rg = decode(k, la_a[k], idx);
          case (rg)
            1: begin
              mem_m[k][idx] = merge(mem_m[k][idx], la_w[k], la_we[k]);
              kn_m[k][idx]  = kn_m[k][idx] | la_we[k];
            end
            2: nmt = merge(mt_m[k], la_w[k], la_we[k]);
            3: mc_m[k] = merge(mc_m[k], la_w[k], la_we[k]);
            default: ;
          endcase
        end
        mt_m[k] = nmt;
        if (er) pend_c[k] = -1;
        if (valid_s[k] && cyc >= free_c[k]) begin
          pend_c[k] = cyc + 1 + int'(WS_P[k]);
          free_c[k] = pend_c[k] + 1;
          la_a[k] = addr_s[k]; la_w[k] = wdata_s[k]; la_we[k] = we_s[k];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, output logic [31:0] rd, output int lat);
    int t0;
    bit got;
    @(posedge clk); #1;
    valid_s[k] = 1'b1; addr_s[k] = a; wdata_s[k] = wd; we_s[k] = we; t0 = cyc;
    @(posedge clk); #1;
    // scramble request fields after acceptance: the latched copy must be used
    valid_s[k] = 1'b0; addr_s[k] = $urandom; wdata_s[k] = $urandom; we_s[k] = 4'($urandom);
    got = 1'b0; rd = '0; lat = -1;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      if (ready_s[k]) begin got = 1'b1; rd = rdata_s[k]; lat = cyc - t0; end
    end
    if (!got) check($sformatf("ready_timeout[%0d]", k), {31'b0, ready_s[k]}, 32'd1);
    else begin
      check($sformatf("latency[%0d]", k), 32'(lat), 32'(1 + WS_P[k]));
      @(negedge clk);
      check($sformatf("pulse_end[%0d]", k), {31'b0, ready_s[k]}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick(input int k);
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 11);
    if (sel < 8)        a = BASE_P[k] + 32'(4 * sel);
    else if (sel == 8)  a = BASE_P[k] + 32'(4 * (DEPTH_P[k] - 1));
    else if (sel == 9)  a = BASE_P[k] + 32'(4 * DEPTH_P[k]);
    else if (sel == 10) a = TADDR_P[k];
    else                a = TADDR_P[k] + 32'd4;
    return a | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- directed and random sequences ----------------
  initial begin : main
    logic [31:0] rd;
    int lat, pulses, r0;
    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b1; valid_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0; we_s[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, ready_s[0]}, 32'd0);
    check("reset_rdata", rdata_s[0], 32'h0);
    check("reset_irq", {31'b0, irq_s[0]}, 32'd0);

    // full-word write then read, WAIT_STATES=1
    xact(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    check("wr_latency_lit", 32'(lat), 32'd2);
    xact(0, 32'h10, 32'h0, 4'h0, rd, lat);
    check("rd_deadbeef", rd, 32'hDEADBEEF);

    // partial byte write
    xact(0, 32'h20, 32'h11223344, 4'hF, rd, lat);
    xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat);
    xact(0, 32'h22, 32'h0, 4'h0, rd, lat);
    check("byte_merge", rd, 32'h11BB33DD);

    // out-of-range access one word past the end
    xact(0, 32'h0, 32'h01020304, 4'hF, rd, lat);
    xact(0, 32'hFFC, 32'h0BADF00D, 4'hF, rd, lat);
    xact(0, 32'h1000, 32'h0, 4'h0, rd, lat);
    check("oor_rdata", rd, 32'h0);
    check("oor_latency", 32'(lat), 32'd2);
    xact(0, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, lat);
    xact(0, 32'h0, 32'h0, 4'h0, rd, lat);
    check("oor_word0", rd, 32'h01020304);
    xact(0, 32'hFFC, 32'h0, 4'h0, rd, lat);
    check("oor_lastword", rd, 32'h0BADF00D);

    // reset during the RESP cycle of a write
    xact(0, 32'h30, 32'hCAFEF00D, 4'hF, rd, lat);
    @(posedge clk); #1;
    valid_s[0] = 1'b1; addr_s[0] = 32'h30; wdata_s[0] = 32'h12345678; we_s[0] = 4'hF;
    @(posedge clk); #1;
    valid_s[0] = 1'b0;
    @(posedge clk); #1;
    rst_s[0] = 1'b1;
    @(negedge clk);
    check("rst_resp_ready", {31'b0, ready_s[0]}, 32'd1);
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    @(negedge clk);
    check("rst_after_ready", {31'b0, ready_s[0]}, 32'd0);
    xact(0, 32'h30, 32'h0, 4'h0, rd, lat);
    check("rst_no_commit", rd, 32'hCAFEF00D);

    // WAIT_STATES=0 with valid held high: pulse every second cycle
    xact(1, 32'h1008, 32'h5A5A0001, 4'hF, rd, lat);
    @(posedge clk); #1;
    valid_s[1] = 1'b1; addr_s[1] = 32'h1008; we_s[1] = 4'h0; wdata_s[1] = 32'h0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ws0_pattern", {31'b0, ready_s[1]}, 32'(i % 2));
      if (ready_s[1]) begin
        pulses++;
        check("ws0_rdata", rdata_s[1], 32'h5A5A0001);
      end else check("ws0_idle_rdata", rdata_s[1], 32'h0);
    end
    @(posedge clk); #1;
    valid_s[1] = 1'b0;
    check("ws0_pulses", 32'(pulses), 32'd5);
    repeat (2) @(negedge clk);

    // WAIT_STATES=3 with a non-zero base
    xact(2, 32'h8000_0004, 32'h0F0E0D0C, 4'hF, rd, lat);
    check("ws3_latency_lit", 32'(lat), 32'd4);
    xact(2, 32'h8000_0004, 32'h0, 4'h0, rd, lat);
    check("ws3_rdata", rd, 32'h0F0E0D0C);

`ifdef DMEM_TIMER_EN
    // timer compare: irq one cycle after mtime reaches mtimecmp
    @(posedge clk); #1;
    rst_s[0] = 1'b1; r0 = cyc;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    xact(0, 32'h0002_0004, 32'd100, 4'hF, rd, lat);
    do @(negedge clk); while (cyc < r0 + 101);
    check("irq_before", {31'b0, irq_s[0]}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'b0, irq_s[0]}, 32'd1);
    xact(0, 32'h0002_0004, 32'hFFFFFFFF, 4'hF, rd, lat);
    check("irq_hold", {31'b0, irq_s[0]}, 32'd1);
    @(negedge clk);
    check("irq_fall", {31'b0, irq_s[0]}, 32'd0);
`else
    r0 = 0;
`endif

    // randomized traffic on all instances, including sporadic resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        rst_s[k]   = ($urandom_range(0, 99) == 0);
        valid_s[k] = ($urandom_range(0, 2) != 0);
        addr_s[k]  = pick(k);
        wdata_s[k] = $urandom;
        we_s[k]    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin rst_s[k] = 1'b0; valid_s[k] = 1'b0; end
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
